board_ctrl: RTL and testbench
=============================

BOARD_CTRL -- requirements
Module: board_ctrl

Interface
REQ-001 SHALL have parameter THINK_CYCLES, default 4, meaning the number of cycles the CPU result is allowed to settle before sampling (range 1..15).
REQ-002 SHALL have ports:
- clock  in  1  sole clock; all state updates on the rising edge.
- reset_n  in  1  synchronous, active-low reset.
- new_game  in  1  level sampled each cycle; 1 clears the board.
- jog_valid  in  1  one-cycle strobe for a human move.
- jog_pos  in  4  human cell index 0..8, row-major.
- cpu_pos  in  4  CPU move index 0..8, from the CPU move generator (coordenadas).
- matriz  out  18  board; cell i at bits [2i+1:2i]; 2'd2 empty, 2'd1 human, 2'd0 CPU, 2'd3 never driven.
- turn  out  1  0 means human to move, 1 means CPU thinking/applying.
- status  out  2  0 playing, 1 human win, 2 CPU win, 3 draw.
- move_count  out  4  moves placed in the current game, 0..9.
- err  out  1  one-cycle pulse: the human move was rejected.
- cpu_err  out  1  one-cycle pulse: the CPU move was invalid and the fallback was used.

Function
REQ-003 SHALL implement the FSM states WAIT_H, CHECK_H, CPU_THINK, CPU_APPLY, CHECK_C and OVER.
REQ-004 In WAIT_H with jog_valid=1:
- jog_pos<=8 and cell empty: write 2'd1, move_count+1, go to CHECK_H; the write is visible on matriz the next cycle.
- jog_pos>8 or cell occupied: err=1 for one cycle; board unchanged; stay in WAIT_H.
REQ-005 jog_valid SHALL be ignored in every state except WAIT_H, with no err.
REQ-006 CHECK_H SHALL evaluate the 8 lines (3 rows, 3 columns, 2 diagonals), then:
- human line: status=1, go to OVER.
- else move_count==9: status=3, go to OVER.
- else: turn=1, go to CPU_THINK.
REQ-007 CPU_THINK SHALL hold for exactly THINK_CYCLES cycles using a 4-bit down-counter, then go to CPU_APPLY.
REQ-008 CPU_APPLY SHALL sample cpu_pos once:
- valid and empty: write 2'd0 there.
- otherwise: write 2'd0 to the lowest-index empty cell and pulse cpu_err.
- in both cases: move_count+1, go to CHECK_C.
REQ-009 CHECK_C SHALL check as CHECK_H does:
- CPU line: status=2, go to OVER.
- else move_count==9: status=3, go to OVER.
- else: turn=0, go to WAIT_H.
REQ-010 OVER SHALL hold matriz, status and move_count until new_game=1.
REQ-011 new_game=1 in any state SHALL take priority over all other inputs; next cycle: all cells 2'd2, status=0, move_count=0, turn=0, state WAIT_H.
REQ-012 err and cpu_err SHALL never be high for more than one consecutive cycle.
REQ-013 The human always moves first; the latency from an accepted jog_valid to the CPU write SHALL be THINK_CYCLES+2 cycles.
REQ-014 A win and a full board in the same check SHALL report the win, not the draw.

Reset
REQ-015 With reset_n=0 at a rising edge, the block SHALL set: all cells 2'd2, status=0, turn=0, move_count=0, err=0, cpu_err=0, think counter 0, state WAIT_H.
REQ-016 Reset SHALL override new_game and every other input, including mid-game and during CPU_THINK; no partial writes SHALL survive.

Configuration
REQ-017 The macro BOARD_SCORE_EN SHALL control score keeping:
- defined: add outputs score_h and score_c, 4 bits each, cleared only by reset (not by new_game); increment on entry to OVER with status 1 or 2 respectively; saturate at 15.
- undefined: these ports and registers are absent; all other behaviour is identical.

Verification
REQ-018 Reset, then jog_valid with jog_pos=4: matriz[9:8]=2'd1 next cycle; turn=1 two cycles after the strobe; CPU write 6 cycles after the strobe (THINK_CYCLES=4).
REQ-019 jog_pos=9, then jog_pos onto a CPU-occupied cell: err pulses once for each; matriz and move_count unchanged.
REQ-020 Human plays 0, 1, 2 while cpu_pos selects 3, 4: status=1 after the third human move; further jog_valid ignored; new_game clears to all-empty, status=0.
REQ-021 cpu_pos=4 while cell 4 is already occupied: cpu_err pulses; lowest empty index receives 2'd0.
REQ-022 Full-board game with no line: status=3 and move_count=9; a final move completing a line on the full board gives the win status instead.
REQ-023 reset_n=0 during CPU_THINK: the next cycle shows an empty board and WAIT_H; with BOARD_SCORE_EN defined, 16 human wins leave score_h=15.

Source files
------------

// File: rtl/board_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | board_ctrl_if -- move/board signal bundle for board_ctrl.   Rev 1.0      |
// +--------------------------------------------------------------------------+
interface board_ctrl_if;
  logic        new_game;
  logic        jog_valid;
  logic [3:0]  jog_pos;
  logic [3:0]  cpu_pos;
  logic [17:0] matriz;
  logic        turn;
  logic [1:0]  status;
  logic [3:0]  move_count;
  logic        err;
  logic        cpu_err;
`ifdef BOARD_SCORE_EN
  logic [3:0]  score_h;
  logic [3:0]  score_c;
`endif

  modport master (
    output new_game, jog_valid, jog_pos, cpu_pos,
`ifdef BOARD_SCORE_EN
    input  score_h, score_c,
`endif
    input  matriz, turn, status, move_count, err, cpu_err
  );

  modport slave (
    input  new_game, jog_valid, jog_pos, cpu_pos,
`ifdef BOARD_SCORE_EN
    output score_h, score_c,
`endif
    output matriz, turn, status, move_count, err, cpu_err
  );
endinterface
`default_nettype wire

// File: rtl/board_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | board_ctrl -- tic-tac-toe game controller (human vs CPU move generator);  |
// | BOARD_SCORE_EN adds saturating win counters.                 Rev 1.0      |
// +--------------------------------------------------------------------------+
module board_ctrl #(
  parameter int unsigned THINK_CYCLES = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  board_ctrl_if.slave bus
);

  localparam logic [2:0]  WAIT_H     = 3'd0;
  localparam logic [2:0]  CHECK_H    = 3'd1;
  localparam logic [2:0]  CPU_THINK  = 3'd2;
  localparam logic [2:0]  CPU_APPLY  = 3'd3;
  localparam logic [2:0]  CHECK_C    = 3'd4;
  localparam logic [2:0]  OVER       = 3'd5;

  localparam logic [1:0]  CELL_CPU   = 2'd0;
  localparam logic [1:0]  CELL_HUMAN = 2'd1;
  localparam logic [1:0]  CELL_EMPTY = 2'd2;

  localparam logic [1:0]  ST_PLAY    = 2'd0;
  localparam logic [1:0]  ST_HWIN    = 2'd1;
  localparam logic [1:0]  ST_CWIN    = 2'd2;
  localparam logic [1:0]  ST_DRAW    = 2'd3;

  localparam logic [17:0] EMPTY_BOARD = {9{CELL_EMPTY}};
  localparam logic [3:0]  THINK_LOAD  = 4'(THINK_CYCLES);
  localparam logic [3:0]  FULL_COUNT  = 4'd9;

  logic [2:0]  state_q,  state_d;
  logic [17:0] matriz_q, matriz_d;
  logic        turn_q,   turn_d;
  logic [1:0]  status_q, status_d;
  logic [3:0]  count_q,  count_d;
  logic [3:0]  think_q,  think_d;
  logic        err_q,    err_d;
  logic        cpu_err_q, cpu_err_d;

  // Indices above 8 read back as the never-driven code, so they never look empty.
  function automatic logic [1:0] cell_at(input logic [17:0] b, input logic [3:0] idx);
    cell_at = 2'd3;
    for (int i = 0; i < 9; i++)
      if (idx == 4'(i)) cell_at = b[2*i +: 2];
  endfunction

  function automatic logic [17:0] set_cell(input logic [17:0] b, input logic [3:0] idx,
                                           input logic [1:0] v);
    set_cell = b;
    for (int i = 0; i < 9; i++)
      if (idx == 4'(i)) set_cell[2*i +: 2] = v;
  endfunction

  function automatic logic has_line(input logic [17:0] b, input logic [1:0] who);
    logic [8:0] m;
    for (int i = 0; i < 9; i++) m[i] = (b[2*i +: 2] == who);
    has_line = (&m[2:0]) | (&m[5:3]) | (&m[8:6]) |
               (m[0] & m[3] & m[6]) | (m[1] & m[4] & m[7]) | (m[2] & m[5] & m[8]) |
               (m[0] & m[4] & m[8]) | (m[2] & m[4] & m[6]);
  endfunction

  function automatic logic [3:0] first_empty(input logic [17:0] b);
    first_empty = 4'd0;
    for (int i = 8; i >= 0; i--)
      if (b[2*i +: 2] == CELL_EMPTY) first_empty = 4'(i);
  endfunction

  logic       human_ok;
  logic       cpu_ok;
  logic [3:0] cpu_idx;
  logic       h_line;
  logic       c_line;

  assign human_ok = (cell_at(matriz_q, bus.jog_pos) == CELL_EMPTY);
  assign cpu_ok   = (cell_at(matriz_q, bus.cpu_pos) == CELL_EMPTY);
  assign cpu_idx  = cpu_ok ? bus.cpu_pos : first_empty(matriz_q);
  assign h_line   = has_line(matriz_q, CELL_HUMAN);
  assign c_line   = has_line(matriz_q, CELL_CPU);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q   <= WAIT_H;
      matriz_q  <= EMPTY_BOARD;
      turn_q    <= 1'b0;
      status_q  <= ST_PLAY;
      count_q   <= 4'd0;
      think_q   <= 4'd0;
      err_q     <= 1'b0;
      cpu_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      matriz_q  <= matriz_d;
      turn_q    <= turn_d;
      status_q  <= status_d;
      count_q   <= count_d;
      think_q   <= think_d;
      err_q     <= err_d;
      cpu_err_q <= cpu_err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      WAIT_H:    if (bus.jog_valid && human_ok) state_d = CHECK_H;
      CHECK_H:   state_d = (h_line || count_q == FULL_COUNT) ? OVER : CPU_THINK;
      CPU_THINK: if (think_q <= 4'd1) state_d = CPU_APPLY;
      CPU_APPLY: state_d = CHECK_C;
      CHECK_C:   state_d = (c_line || count_q == FULL_COUNT) ? OVER : WAIT_H;
      OVER:      state_d = OVER;
      default:   state_d = WAIT_H;
    endcase
    if (bus.new_game) state_d = WAIT_H;
  end

  always_comb begin
    matriz_d  = matriz_q;
    turn_d    = turn_q;
    status_d  = status_q;
    count_d   = count_q;
    think_d   = think_q;
    err_d     = 1'b0;
    cpu_err_d = 1'b0;
    case (state_q)
      WAIT_H: begin
        if (bus.jog_valid) begin
          if (human_ok) begin
            matriz_d = set_cell(matriz_q, bus.jog_pos, CELL_HUMAN);
            count_d  = count_q + 4'd1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      CHECK_H: begin
        if (h_line) begin
          status_d = ST_HWIN;
        end else if (count_q == FULL_COUNT) begin
          status_d = ST_DRAW;
        end else begin
          turn_d  = 1'b1;
          think_d = THINK_LOAD;
        end
      end
      CPU_THINK: think_d = (think_q == 4'd0) ? 4'd0 : think_q - 4'd1;
      CPU_APPLY: begin
        matriz_d  = set_cell(matriz_q, cpu_idx, CELL_CPU);
        cpu_err_d = !cpu_ok;
        count_d   = count_q + 4'd1;
      end
      CHECK_C: begin
        turn_d = 1'b0;
        if (c_line)                     status_d = ST_CWIN;
        else if (count_q == FULL_COUNT) status_d = ST_DRAW;
      end
      default: ;
    endcase
    if (bus.new_game) begin
      matriz_d  = EMPTY_BOARD;
      turn_d    = 1'b0;
      status_d  = ST_PLAY;
      count_d   = 4'd0;
      think_d   = 4'd0;
      err_d     = 1'b0;
      cpu_err_d = 1'b0;
    end
  end

  assign bus.matriz     = matriz_q;
  assign bus.turn       = turn_q;
  assign bus.status     = status_q;
  assign bus.move_count = count_q;
  assign bus.err        = err_q;
  assign bus.cpu_err    = cpu_err_q;

`ifdef BOARD_SCORE_EN
  logic [3:0] score_h_q, score_h_d;
  logic [3:0] score_c_q, score_c_d;

  // Counted on the transition into OVER; new_game leaves the tallies alone.
  always_comb begin
    score_h_d = score_h_q;
    score_c_d = score_c_q;
    if (state_d == OVER && state_q != OVER) begin
      if (status_d == ST_HWIN && score_h_q != 4'hF) score_h_d = score_h_q + 4'd1;
      if (status_d == ST_CWIN && score_c_q != 4'hF) score_c_d = score_c_q + 4'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      score_h_q <= 4'd0;
      score_c_q <= 4'd0;
    end else begin
      score_h_q <= score_h_d;
      score_c_q <= score_c_d;
    end
  end

  assign bus.score_h = score_h_q;
  assign bus.score_c = score_c_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_board_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_board_ctrl -- directed and random games against a move-level model.    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_board_ctrl;
  localparam int T = 4;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;

  board_ctrl_if bus ();

  board_ctrl #(.THINK_CYCLES(T)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int fails  = 0;

  // Game model: 2 empty, 1 human, 0 CPU
  int mb[9];
  int m_status;
  int m_count;
  bit m_over;
  int lines[8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                      '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [17:0] packb();
    logic [17:0] r;
    for (int i = 0; i < 9; i++) r[2*i +: 2] = 2'(mb[i]);
    return r;
  endfunction

  function automatic bit m_line(input int who);
    for (int l = 0; l < 8; l++)
      if (mb[lines[l][0]] == who && mb[lines[l][1]] == who && mb[lines[l][2]] == who)
        return 1'b1;
    return 1'b0;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic m_clear();
    for (int i = 0; i < 9; i++) mb[i] = 2;
    m_status = 0;
    m_count  = 0;
    m_over   = 1'b0;
  endtask

  task automatic check_board(input string tag);
    chk({tag, "_matriz"}, bus.matriz, packb());
    chk({tag, "_count"}, bus.move_count, m_count);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    m_clear();
    check_board("reset");
    chk("reset_status", bus.status, 0);
    chk("reset_turn", bus.turn, 0);
    chk("reset_err", bus.err, 0);
    chk("reset_cpu_err", bus.cpu_err, 0);
  endtask

  task automatic new_game_step();
    bus.new_game = 1'b1;
    tick();
    bus.new_game = 1'b0;
    m_clear();
    check_board("newgame");
    chk("newgame_status", bus.status, 0);
    chk("newgame_turn", bus.turn, 0);
  endtask

  // One human strobe followed by the full CPU reply, checked against the model.
  task automatic human_move(input int pos, input int cpu);
    bit legal;
    int ci;
    bit cerr;
    bus.jog_pos   = 4'(pos);
    bus.cpu_pos   = 4'(cpu);
    bus.jog_valid = 1'b1;
    tick();
    bus.jog_valid = 1'b0;
    if (m_over) begin
      chk("over_ignore_err", bus.err, 0);
      check_board("over_ignore");
      chk("over_status", bus.status, m_status);
      return;
    end
    legal = 1'b0;
    if (pos <= 8) legal = (mb[pos] == 2);
    if (!legal) begin
      chk("rej_err", bus.err, 1);
      check_board("rej");
      tick();
      chk("rej_err_pulse", bus.err, 0);
      check_board("rej_hold");
      return;
    end
    mb[pos] = 1;
    m_count++;
    chk("h_err", bus.err, 0);
    check_board("h_write");
    chk("h_turn", bus.turn, 0);
    tick();
    if (m_line(1)) begin
      m_status = 1; m_over = 1'b1;
    end else if (m_count == 9) begin
      m_status = 3; m_over = 1'b1;
    end
    chk("h_status", bus.status, m_status);
    if (m_over) return;
    chk("think_turn", bus.turn, 1);
    repeat (T) tick();
    check_board("think_hold");
    tick();
    cerr = 1'b1;
    ci   = -1;
    if (cpu <= 8) if (mb[cpu] == 2) begin ci = cpu; cerr = 1'b0; end
    if (ci < 0) begin
      for (int i = 8; i >= 0; i--) if (mb[i] == 2) ci = i;
    end
    mb[ci] = 0;
    m_count++;
    check_board("cpu_write");
    chk("cpu_err", bus.cpu_err, cerr);
    tick();
    chk("cpu_err_pulse", bus.cpu_err, 0);
    if (m_line(0)) begin
      m_status = 2; m_over = 1'b1;
    end else if (m_count == 9) begin
      m_status = 3; m_over = 1'b1;
    end
    chk("c_status", bus.status, m_status);
    if (!m_over) chk("c_turn", bus.turn, 0);
  endtask

  initial begin
    bus.new_game  = 1'b0;
    bus.jog_valid = 1'b0;
    bus.jog_pos   = 4'd0;
    bus.cpu_pos   = 4'd0;
    m_clear();

    // Basic latency, then rejects of out-of-range and CPU-occupied cells
    do_reset();
    human_move(4, 0);
    human_move(9, 1);
    human_move(0, 1);

    // Human wins on the top row; later strobes ignored
    new_game_step();
    human_move(0, 3);
    human_move(1, 4);
    human_move(2, 5);
    chk("hwin_status", bus.status, 1);
    human_move(6, 7);
    new_game_step();

    // CPU asks for an occupied cell -> fallback to lowest empty
    human_move(4, 4);

    // Draw on a full board with no line
    new_game_step();
    human_move(0, 4);
    human_move(2, 1);
    human_move(7, 6);
    human_move(3, 5);
    human_move(8, 0);
    chk("draw_status", bus.status, 3);
    chk("draw_count", bus.move_count, 9);

    // Win completed by the ninth move beats the draw
    new_game_step();
    human_move(0, 2);
    human_move(1, 3);
    human_move(4, 6);
    human_move(5, 7);
    human_move(8, 0);
    chk("fullwin_status", bus.status, 1);

    // Reset in the middle of CPU_THINK
    new_game_step();
    bus.jog_pos   = 4'd4;
    bus.jog_valid = 1'b1;
    tick();
    bus.jog_valid = 1'b0;
    tick();
    tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    m_clear();
    check_board("think_reset");
    chk("think_reset_turn", bus.turn, 0);
    chk("think_reset_status", bus.status, 0);
    human_move(4, 0);

    // Random games
    for (int g = 0; g < 6; g++) begin
      new_game_step();
      for (int s = 0; s < 40; s++) begin
        if (m_over) break;
        human_move(int'($urandom_range(0, 10)), int'($urandom_range(0, 12)));
      end
      human_move(int'($urandom_range(0, 8)), 0);
    end

`ifdef BOARD_SCORE_EN
    do_reset();
    for (int g = 0; g < 16; g++) begin
      new_game_step();
      human_move(0, 3);
      human_move(1, 4);
      human_move(2, 5);
    end
    chk("score_h_sat", bus.score_h, 15);
    chk("score_c_zero", bus.score_c, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
`default_nettype wire
